// File: rtl/emergency_stop_manager.sv
// Multi-source emergency stop manager: per-source debounce, optional latching,
// stop/release FSM with hold-off, and trigger/event reporting.
module emergency_stop_manager #(
   parameter int unsigned       N_SRC      = 4,
   parameter int unsigned       DEB_CYC    = 3,
   parameter int unsigned       HOLD_CYC   = 8,
   parameter logic [N_SRC-1:0]  LATCH_MASK = N_SRC'(4'b0001),
   parameter int unsigned       CNT_W      = 8,
   localparam int unsigned      TRIG_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [N_SRC-1:0]  emergency_in,
   input  logic              clear_req,
   output logic              emergency_stopped,
   output logic              releasing,
   output logic [N_SRC-1:0]  stop_cause,
   output logic [TRIG_W-1:0] trigger_src,
   output logic              trigger_valid,
   output logic [CNT_W-1:0]  event_count
);

   localparam int unsigned DEB_W     = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
   localparam int unsigned HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam int unsigned HOLD_LAST = (HOLD_CYC == 0) ? 0 : HOLD_CYC - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STOPPED,
      S_RELEASING
   } state_t;

   state_t              state, state_nxt;
   logic [N_SRC-1:0]    filt;
   logic [N_SRC-1:0]    latch;
   logic [N_SRC-1:0]    deb_fire;
   logic [N_SRC-1:0]    rise_now;
   logic [DEB_W-1:0]    deb_cnt [N_SRC];
   logic [HOLD_W-1:0]   hold_cnt;
   logic [TRIG_W-1:0]   first_src;
   logic                any_cause;
   logic                hold_done;
   logic                found;

   always_comb begin
      deb_fire = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         deb_fire[i] = (emergency_in[i] != filt[i]) && (deb_cnt[i] == DEB_W'(DEB_CYC - 1));
      end
      rise_now = deb_fire & emergency_in;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt <= '0;
         for (int unsigned i = 0; i < N_SRC; i++) deb_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N_SRC; i++) begin
            if (deb_fire[i]) begin
               filt[i]    <= emergency_in[i];
               deb_cnt[i] <= '0;
            end else if (emergency_in[i] != filt[i]) begin
               deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   // A filter rise on the same edge as clear_req keeps the latch set
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) latch <= '0;
      else          latch <= LATCH_MASK & (filt | rise_now | (latch & ~{N_SRC{clear_req}}));
   end

   always_comb begin
      stop_cause = filt | latch;
      any_cause  = |stop_cause;
      hold_done  = (hold_cnt == HOLD_W'(HOLD_LAST));
      first_src  = '0;
      found      = 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (stop_cause[i] && !found) begin
            first_src = TRIG_W'(i);
            found     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (any_cause) state_nxt = S_STOPPED;
         S_STOPPED:   if (!any_cause) state_nxt = (HOLD_CYC == 0) ? S_IDLE : S_RELEASING;
         S_RELEASING: begin
            if (any_cause)      state_nxt = S_STOPPED;
            else if (hold_done) state_nxt = S_IDLE;
         end
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      emergency_stopped = (state != S_IDLE);
      releasing         = (state == S_RELEASING);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_cnt      <= '0;
         trigger_src   <= '0;
         trigger_valid <= 1'b0;
         event_count   <= '0;
      end else begin
         if (state == S_STOPPED)
            hold_cnt <= '0;
         else if (state == S_RELEASING && !any_cause)
            hold_cnt <= hold_cnt + HOLD_W'(1);
         if (state == S_IDLE && any_cause) begin
            trigger_src   <= first_src;
            trigger_valid <= 1'b1;
            if (event_count != '1) event_count <= event_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_emergency_stop_manager.sv
// Directed bench for emergency_stop_manager (CNT_W=2 so saturation is reachable).
module tb_emergency_stop_manager;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] ein = '0;
   logic       clr = 1'b0;
   logic       stop, rel, tv;
   logic [3:0] cause;
   logic [1:0] trig;
   logic [1:0] cnt;

   int checks = 0;
   int failures = 0;

   emergency_stop_manager #(.N_SRC(4), .DEB_CYC(3), .HOLD_CYC(8), .LATCH_MASK(4'b0001), .CNT_W(2)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .emergency_in      (ein),
      .clear_req         (clr),
      .emergency_stopped (stop),
      .releasing         (rel),
      .stop_cause        (cause),
      .trigger_src       (trig),
      .trigger_valid     (tv),
      .event_count       (cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] ein;
      logic       clr;
      int         n;
      logic       stop;
      logic       rel;
      logic [3:0] cause;
      logic [1:0] cnt;
      logic [1:0] trig;
      logic       tv;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      ein     = '0;
      clr     = 1'b0;
      step(2);
      reset_n = 1'b1;
   endtask

   task automatic chk_all(input string tag, input logic s, input logic r, input logic [3:0] c,
                          input logic [1:0] n, input logic [1:0] t, input logic v);
      chk({tag, "_stop"},  8'(stop),  8'(s));
      chk({tag, "_rel"},   8'(rel),   8'(r));
      chk({tag, "_cause"}, 8'(cause), 8'(c));
      chk({tag, "_cnt"},   8'(cnt),   8'(n));
      chk({tag, "_trig"},  8'(trig),  8'(t));
      chk({tag, "_tv"},    8'(tv),    8'(v));
   endtask

   task automatic episode(input logic [3:0] mask);
      ein = mask;
      step(4);
      ein = '0;
      step(12);
   endtask

   initial begin
      // glitch rejection, auto-release, latched source
      tbl.push_back('{4'b0010, 1'b0, 2, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0});
      tbl.push_back('{4'b0000, 1'b0, 5, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0});
      tbl.push_back('{4'b0100, 1'b0, 3, 1'b0, 1'b0, 4'b0100, 2'd0, 2'd0, 1'b0});
      tbl.push_back('{4'b0100, 1'b0, 1, 1'b1, 1'b0, 4'b0100, 2'd1, 2'd2, 1'b1});
      tbl.push_back('{4'b0100, 1'b0, 6, 1'b1, 1'b0, 4'b0100, 2'd1, 2'd2, 1'b1});
      tbl.push_back('{4'b0000, 1'b0, 2, 1'b1, 1'b0, 4'b0100, 2'd1, 2'd2, 1'b1});
      tbl.push_back('{4'b0000, 1'b0, 1, 1'b1, 1'b0, 4'b0000, 2'd1, 2'd2, 1'b1});
      tbl.push_back('{4'b0000, 1'b0, 1, 1'b1, 1'b1, 4'b0000, 2'd1, 2'd2, 1'b1});
      tbl.push_back('{4'b0000, 1'b0, 7, 1'b1, 1'b1, 4'b0000, 2'd1, 2'd2, 1'b1});
      tbl.push_back('{4'b0000, 1'b0, 1, 1'b0, 1'b0, 4'b0000, 2'd1, 2'd2, 1'b1});
      tbl.push_back('{4'b0001, 1'b0, 3, 1'b0, 1'b0, 4'b0001, 2'd1, 2'd2, 1'b1});
      tbl.push_back('{4'b0001, 1'b0, 1, 1'b1, 1'b0, 4'b0001, 2'd2, 2'd0, 1'b1});
      tbl.push_back('{4'b0001, 1'b1, 1, 1'b1, 1'b0, 4'b0001, 2'd2, 2'd0, 1'b1});
      tbl.push_back('{4'b0001, 1'b0, 1, 1'b1, 1'b0, 4'b0001, 2'd2, 2'd0, 1'b1});
      tbl.push_back('{4'b0000, 1'b0, 3, 1'b1, 1'b0, 4'b0001, 2'd2, 2'd0, 1'b1});
      tbl.push_back('{4'b0000, 1'b0, 2, 1'b1, 1'b0, 4'b0001, 2'd2, 2'd0, 1'b1});
      tbl.push_back('{4'b0000, 1'b1, 1, 1'b1, 1'b0, 4'b0000, 2'd2, 2'd0, 1'b1});
      tbl.push_back('{4'b0000, 1'b0, 1, 1'b1, 1'b1, 4'b0000, 2'd2, 2'd0, 1'b1});
      tbl.push_back('{4'b0000, 1'b0, 7, 1'b1, 1'b1, 4'b0000, 2'd2, 2'd0, 1'b1});
      tbl.push_back('{4'b0000, 1'b0, 1, 1'b0, 1'b0, 4'b0000, 2'd2, 2'd0, 1'b1});

      do_reset();
      chk_all("reset", 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0);

      foreach (tbl[r]) begin
         ein = tbl[r].ein;
         clr = tbl[r].clr;
         step(tbl[r].n);
         chk_all($sformatf("row%0d", r), tbl[r].stop, tbl[r].rel, tbl[r].cause,
                 tbl[r].cnt, tbl[r].trig, tbl[r].tv);
      end
      clr = 1'b0;

      // re-trigger during hold-off
      do_reset();
      ein = 4'b0100;
      step(4);
      chk_all("rt_stop", 1'b1, 1'b0, 4'b0100, 2'd1, 2'd2, 1'b1);
      ein = '0;
      step(4);
      chk_all("rt_rel1", 1'b1, 1'b1, 4'b0000, 2'd1, 2'd2, 1'b1);
      step(3);
      ein = 4'b1000;
      step(3);
      chk_all("rt_rel7", 1'b1, 1'b1, 4'b1000, 2'd1, 2'd2, 1'b1);
      step(1);
      chk_all("rt_reent", 1'b1, 1'b0, 4'b1000, 2'd1, 2'd2, 1'b1);
      step(1);
      ein = '0;
      step(4);
      chk_all("rt_hold1", 1'b1, 1'b1, 4'b0000, 2'd1, 2'd2, 1'b1);
      step(7);
      chk_all("rt_hold8", 1'b1, 1'b1, 4'b0000, 2'd1, 2'd2, 1'b1);
      step(1);
      chk_all("rt_idle", 1'b0, 1'b0, 4'b0000, 2'd1, 2'd2, 1'b1);

      // priority and counter saturation
      do_reset();
      ein = 4'b1010;
      step(4);
      chk_all("prio", 1'b1, 1'b0, 4'b1010, 2'd1, 2'd1, 1'b1);
      ein = '0;
      step(12);
      chk("prio_idle", 8'(stop), 8'd0);
      episode(4'b0100);
      chk("sat_cnt2", 8'(cnt), 8'd2);
      episode(4'b0100);
      chk("sat_cnt3", 8'(cnt), 8'd3);
      episode(4'b0100);
      episode(4'b0100);
      chk_all("sat_end", 1'b0, 1'b0, 4'b0000, 2'd3, 2'd2, 1'b1);

      // asynchronous reset mid-stop with latched source
      do_reset();
      ein = 4'b0001;
      step(4);
      chk_all("ar_pre", 1'b1, 1'b0, 4'b0001, 2'd1, 2'd0, 1'b1);
      #3 reset_n = 1'b0;
      #1;
      chk_all("ar_async", 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0);
      #2 reset_n = 1'b1;
      step(3);
      chk_all("ar_deb", 1'b0, 1'b0, 4'b0001, 2'd0, 2'd0, 1'b0);
      step(1);
      chk_all("ar_restop", 1'b1, 1'b0, 4'b0001, 2'd1, 2'd0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/emergency_stop_manager.md
Name: emergency_stop_manager

Overview:
Parametrised successor to the single-input emergency stop latch. Accepts N_SRC independent emergency sources (stop button, door obstruction, overload, shaft fault, etc.). Each source is debounced and is either latching (requires operator clear) or auto-releasing. Produces one stop command for the motion/door controllers with a release hold-off, plus cause reporting and an event counter for the elevator top level.

Parameters:
N_SRC, 4, number of emergency sources (>=1)
DEB_CYC, 3, consecutive cycles a raw input must differ from its filtered value before the filter flips (>=1)
HOLD_CYC, 8, cycles all causes must stay clear before the stop releases (0 = immediate)
LATCH_MASK, 4'b0001, per-source bit; 1 = latching source, 0 = auto-release
CNT_W, 8, event counter width

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
emergency_in  input  N_SRC  raw emergency requests, synchronous to clk, active high
clear_req  input  1  operator clear for latched sources (level, sampled each edge)
emergency_stopped  output  1  stop command; high in STOPPED and RELEASING
releasing  output  1  high only in RELEASING
stop_cause  output  N_SRC  current cause vector
trigger_src  output  $clog2(N_SRC) (min 1)  source that caused the most recent IDLE->STOPPED entry
trigger_valid  output  1  high once any stop has been entered since reset
event_count  output  CNT_W  number of IDLE->STOPPED entries, saturating

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; all filters, latches, debounce/hold counters, trigger_src, trigger_valid and event_count go to 0. All outputs are 0 while reset_n is low. After release, inputs held high are re-debounced from zero.
- Debounce, per source i:
  - Counter increments each edge where emergency_in[i] != f[i]. It resets to 0 on any edge where they are equal.
  - When the counter would reach DEB_CYC, f[i] takes emergency_in[i] and the counter clears.
  - A raw rise sampled at edges 1..DEB_CYC sets f[i] after edge DEB_CYC. Falls are filtered identically.
- Latch l[i], for LATCH_MASK[i]=1 only:
  - Sets on any edge with f[i]=1.
  - Clears on an edge with clear_req=1 and f[i]=0.
  - clear_req while f[i]=1 is ignored. It is not remembered.
  - For LATCH_MASK[i]=0, l[i] stays 0.
- stop_cause[i] = f[i] | l[i]. This is combinational from registers. any_cause = |stop_cause.
- FSM (registered state):
  - IDLE: any_cause -> STOPPED. On this edge, trigger_src gets the lowest index i with stop_cause[i]=1, trigger_valid is set, and event_count increments unless it is all ones.
  - STOPPED: !any_cause -> RELEASING with hold counter = 0. If HOLD_CYC=0, go directly to IDLE.
  - RELEASING:
    - any_cause -> STOPPED. This is a re-entry: no count increment, trigger_src unchanged.
    - Otherwise the hold counter increments.
    - When the counter reaches HOLD_CYC-1, go to IDLE on that edge. RELEASING therefore lasts exactly HOLD_CYC cycles.
- Latency: with an auto-release source and emergency_in rising before edge 1, emergency_stopped goes high after edge DEB_CYC+1.
- trigger_src/trigger_valid hold their values through release. They update only on the next IDLE->STOPPED entry.
- Simultaneous events:
  - Several sources qualifying on the same edge: lowest index wins trigger_src.
  - clear_req and a new f[i] rise on the same edge: the latch stays set.
  - Counter saturation: stops at 2^CNT_W-1 and never wraps.

Test Plan:
1. Glitch rejection (defaults): emergency_in[1] high for 2 cycles then low -> emergency_stopped stays 0, stop_cause 0, event_count 0.
2. Auto-release: emergency_in[2] high 10 cycles -> emergency_stopped=1 after edge 4, trigger_src=2, count=1. After the fall, f[2] clears 3 edges later, releasing=1 for exactly 8 cycles, then emergency_stopped=0.
3. Latched: emergency_in[0] high 6 cycles. clear_req pulsed while it is high -> stop_cause[0] stays 1. After the input falls and debounces, a clear_req pulse -> RELEASING 8 cycles -> IDLE.
4. Re-trigger in hold-off: during RELEASING cycle 4, raise emergency_in[3] for 5 cycles -> returns to STOPPED, releasing=0, event_count and trigger_src unchanged, fresh 8-cycle hold after it clears.
5. Priority and saturation (CNT_W=2): emergency_in[1] and [3] rise on the same edge -> trigger_src=1. Five complete stop/release episodes -> event_count=3.
6. Asynchronous reset: assert reset_n=0 mid-STOPPED with l[0]=1 between clock edges -> all outputs 0 immediately. Release with emergency_in[0] held high -> stop re-asserts 4 edges later, event_count=1.
